vedic_column_multiplier: RTL and testbench



---
 rtl/vedic_column_multiplier_pkg.sv | 19 +
 rtl/vedic_column_pp.sv | 42 ++++
 rtl/vedic_column_multiplier.sv | 111 +++++++++++
 tb/tb_vedic_column_multiplier.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vedic_column_multiplier_pkg.sv
// Purpose : shared FSM encoding and width helper for the Vedic column multiplier.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package vedic_column_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a column sum, the running carry and the column index.
    // A column holds at most WIDTH AND terms; with the incoming carry the
    // sum stays below 2*WIDTH. The index tops out at 2*WIDTH-1.
    function automatic int cw_bits(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/vedic_column_pp.sv
// Purpose : popcount of one Urdhva-Tiryagbhyam diagonal (all a[i]&b[j] with i+j=col).
// Latency : combinational.
// Backpressure: none; pure function of a, b, col.
//
// Ports:
//   a, b    operands (WIDTH bits, unsigned)
//   col     diagonal index, 0..2*WIDTH-2
//   pp_cnt  number of set AND terms on that diagonal (CW bits)
module vedic_column_pp
    import vedic_column_multiplier_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cw_bits(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CW-1:0]    col,
    output logic [CW-1:0]    pp_cnt
);

    // Full AND plane; pp_plane[i][j] = a[i] & b[j].
    logic [WIDTH-1:0][WIDTH-1:0] pp_plane;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
            assign pp_plane[gi][gj] = a[gi] & b[gj];
        end
    end

    // Select the anti-diagonal i+j == col and count its ones.
    always_comb begin
        pp_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i + j == int'(col)) begin
                    pp_cnt = pp_cnt + CW'(pp_plane[i][j]);
                end
            end
        end
    end

endmodule

// File: rtl/vedic_column_multiplier.sv
// Purpose : sequential Vedic crosswise unsigned multiplier, one product column per clock.
// Latency : out_valid rises 2*WIDTH-1 cycles after the input accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b captured on accept)
//   a, b                 WIDTH-bit unsigned operands
//   out_valid/out_ready  product handshake
//   product              2*WIDTH-bit a*b, stable while out_valid
module vedic_column_multiplier
    import vedic_column_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cw_bits(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      col_q;
    logic [CW-1:0]      carry_q;
    logic [2*WIDTH-1:0] product_q;
    logic [CW-1:0]      pp_cnt;
    logic [CW-1:0]      col_sum;
    logic               last_col;

    vedic_column_pp #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_pp (
        .a      (a_q),
        .b      (b_q),
        .col    (col_q),
        .pp_cnt (pp_cnt)
    );

    // Cannot overflow: column popcount <= WIDTH and carry stays small enough
    // that the sum is always below 2*WIDTH.
    assign col_sum  = pp_cnt + carry_q;
    assign last_col = (col_q == CW'(2 * WIDTH - 2));

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from in_valid or out_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign product   = product_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_col)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            col_q     <= '0;
            carry_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        col_q     <= '0;
                        carry_q   <= '0;
                        product_q <= '0;
                    end
                end
                ST_RUN: begin
                    product_q[col_q] <= col_sum[0];
                    carry_q          <= col_sum >> 1;
                    col_q            <= col_q + CW'(1);
                    // The final carry is a single bit and becomes the MSB.
                    if (last_col) begin
                        product_q[2*WIDTH-1] <= col_sum[1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_column_multiplier.sv
module tb_vedic_column_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  product4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    vedic_column_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8)
    );

    vedic_column_multiplier #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: plain integer multiplication; latency from the FSM timing
    // contract (2*WIDTH-1 cycles from accept to out_valid).
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return x * y;
    endfunction

    // One W=8 operation. stall = cycles out_ready is held low once out_valid
    // is up; product must stay put during the stall.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int stall,
                       output logic [15:0] prod, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready8 && guard < 100) begin @(negedge clk); guard++; end
        a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = (stall == 0);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        prod = product8;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("w8_stall_hold", product8, prod);
            chk("w8_stall_valid", out_valid8, 1);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("w8_idle_after", in_ready8, 1);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y,
                       output logic [7:0] prod, output int lat);
        @(negedge clk);
        a4 = x; b4 = y; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 100) begin @(posedge clk); #1; lat++; end
        prod = product4;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] p8, held;
        logic [7:0]  p4;
        logic [7:0]  ra, rb;
        int          lat, guard;

        // Reset state
        #12;
        chk("rst_in_ready8", in_ready8, 1);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_product8", product8, 0);
        chk("rst_in_ready4", in_ready4, 1);
        chk("rst_product4", product4, 0);
        @(negedge clk); rst_n = 1'b1;

        // Basic case with latency
        op8(8'd3, 8'd5, 0, p8, lat);
        chk("3x5_lat", lat, 15);
        chk("3x5_prod", p8, 15);

        op8(8'd255, 8'd255, 0, p8, lat);
        chk("255x255", p8, 16'hFE01);
        op8(8'd0, 8'd200, 0, p8, lat);
        chk("0x200", p8, 0);
        op8(8'd1, 8'd173, 0, p8, lat);
        chk("1x173", p8, 173);

        // Held in DONE for 10 cycles with in_valid pulses that must be ignored
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk); #1; in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("200x100_lat", lat, 15);
        held = product8;
        chk("200x100", held, 20000);
        for (int c = 0; c < 10; c++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = c[0];
            @(posedge clk); #1;
            chk("hold_prod", product8, 20000);
            chk("hold_in_ready", in_ready8, 0);
            chk("hold_out_valid", out_valid8, 1);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_idle", in_ready8, 1);
        chk("hold_release_prod", product8, 20000);

        // Reset in the middle of RUN
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd60; in_valid8 = 1'b1;
        @(posedge clk); #1; in_valid8 = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", in_ready8, 1);
        chk("midrun_rst_out_valid", out_valid8, 0);
        chk("midrun_rst_product", product8, 0);
        @(negedge clk); rst_n = 1'b1;
        op8(8'd7, 8'd9, 0, p8, lat);
        chk("7x9_after_rst", p8, 63);

        // Back-to-back with in_valid held high
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd11; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd13; b8 = 8'd13;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("b2b_first_lat", lat, 15);
        chk("b2b_first", product8, 132);
        @(posedge clk); #1;
        chk("b2b_handshake_idle", in_ready8, 1);
        chk("b2b_handshake_valid", out_valid8, 0);
        @(posedge clk); #1;
        chk("b2b_second_accepted", in_ready8, 0);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("b2b_second_lat", lat, 15);
        chk("b2b_second", product8, 169);
        @(posedge clk); #1;

        // Randomized W=8 operations with random output stalls
        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, $urandom_range(0, 3), p8, lat);
            chk("rand8_lat", lat, 15);
            chk("rand8_prod", {16'd0, p8}, ref_mul({24'd0, ra}, {24'd0, rb}));
        end

        // Exhaustive W=4
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                op4(4'(x), 4'(y), p4, lat);
                chk("w4_lat", lat, 7);
                chk("w4_prod", {24'd0, p4}, ref_mul(32'(x), 32'(y)));
            end
        end

        guard = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
